pc_sequencer: RTL
=================

# pc_sequencer

Owns the program counter and drives the 2-bit select of the next-PC 4-way mux. It decides each cycle whether an instruction retires, and sequences the core through run, halt and single-step modes for FPGA bring-up. It sits between the decoder/ALU (branch, jump and zero flags), the PC mux, and the board's run/halt/step buttons. It also counts retired instructions and traps misaligned control-flow targets.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- HALT_ON_RESET, 0: 1 = leave reset in HALT; 0 = leave reset in RUN.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- branch  input  1  decoder: current instruction is a conditional branch.
- zero  input  1  ALU zero flag (branch taken when branch & zero).
- jump  input  1  decoder: direct jump.
- jump_reg  input  1  decoder: jump to register.
- branch_target  input  32  mux in1 source.
- jump_target  input  32  mux in2 source.
- reg_target  input  32  mux in3 source.
- run_req  input  1  debounced level/pulse: enter RUN.
- halt_req  input  1  enter HALT.
- step_req  input  1  single-step from HALT.
- pc  output  32  current PC (registered).
- pc_plus4  output  32  pc + 4, mux in0 source.
- pc_sel  output  2  mux select: 00 seq, 01 branch, 10 jump, 11 jump-reg.
- commit  output  1  current instruction retires this cycle.
- state  output  2  00 RUN, 01 HALT, 10 STEP.
- instr_count  output  32  retired-instruction count.
- misalign  output  1  sticky: a taken target had nonzero bits [1:0].

## Operation
- pc_sel (combinational, priority): jump_reg → 11; else jump → 10; else branch & zero → 01; else 00. Driven in every state, including HALT.
- next_pc = the input selected by pc_sel. pc_plus4 = pc + 32'd4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- commit = (state == RUN) | (state == STEP), and commit is forced 0 while misalign is set.
- On commit, one of two things happens:
  - If next_pc[1:0] != 00 and pc_sel != 00: pc holds, misalign sets, state → HALT, instr_count does not increment.
  - Otherwise: pc ← next_pc and instr_count ← instr_count + 1 (wraps at 2^32).
- FSM request priority: halt_req > run_req > step_req.
  - RUN: halt_req → HALT; else stay.
  - HALT: run_req → RUN; else step_req → STEP; else stay.
  - STEP: run_req (without halt_req) → RUN; else → HALT. STEP lasts exactly one cycle.
  - Encoding 11 is unreachable and recovers to HALT on the next edge.
- misalign clears only on Reset. While misalign is set, run_req and step_req are ignored and the state stays HALT.
- A held step_req produces one step per HALT→STEP→HALT round trip, i.e. one retirement every 2 cycles.

## Timing
- Reset values: pc = RESET_PC, instr_count = 0, misalign = 0, state = HALT if HALT_ON_RESET else RUN. Reset overrides all requests in the same edge.
- pc_sel, pc_plus4 and commit are combinational from the current state and inputs; pc is valid 1 cycle after the committing edge.
- A request sampled at edge N changes state from cycle N+1. The cycle in which halt_req is raised still commits if the state is RUN.
- Latency from step_req (in HALT) to the PC update is 2 edges: the first edge enters STEP, the second commits.
- Reset asserted mid-STEP: no commit occurs on that edge; all outputs take their reset values.

## Test plan
- Reset with HALT_ON_RESET=0 and RESET_PC=0, 4 cycles of sequential flow → pc = 0,4,8,12,16; instr_count = 4; pc_sel = 00 throughout.
- branch=1, zero=1, jump=1, jump_reg=1, reg_target=0x100 → pc_sel = 11; next pc = 0x100. Then branch=1, zero=0, no jumps → pc_sel = 00.
- RUN with halt_req for 1 cycle at pc=0x20 → that cycle commits and pc = 0x24. Then HALT: commit = 0 and pc holds for 10 cycles. Pulse step_req → exactly one retirement, pc = 0x28, back to HALT.
- jump=1 with jump_target = 0x42 in RUN → misalign = 1, pc unchanged, state = HALT, count unchanged. run_req is then ignored until Reset, which clears misalign.
- pc = 0xFFFF_FFFC, sequential flow → pc = 0. instr_count preset by running 2^32−1 retirements (or forced in sim), then one more → instr_count = 0.
- halt_req and run_req together in HALT → stays HALT. Reset asserted in STEP together with step_req → pc = RESET_PC, no increment.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter owner and run/halt/step sequencer for FPGA bring-up.
// Chooses the next-PC mux input, decides retirement, counts retirements and traps misaligned targets.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter bit          HALT_ON_RESET = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] reg_target,
    input  logic        run_req,
    input  logic        halt_req,
    input  logic        step_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [1:0]  pc_sel,
    output logic        commit,
    output logic [1:0]  state,
    output logic [31:0] instr_count,
    output logic        misalign
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_STEP = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    localparam state_t RESET_STATE = HALT_ON_RESET ? ST_HALT : ST_RUN;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] count_r;
    logic        misalign_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] next_pc_s;
    logic [1:0]  pc_sel_s;
    logic        commit_s;
    logic        trap_s;
    logic        retire_s;

    // A redirect is only illegal when a non-sequential source is chosen; pc+4 is always aligned.
    function automatic logic target_misaligned(input logic [1:0] sel, input logic [31:0] target);
        return (sel != 2'b00) && (target[1:0] != 2'b00);
    endfunction

    // Next-PC source priority and mux.
    always_comb begin
        pc_plus4_s = pc_r + 32'd4;
        pc_sel_s   = 2'b00;
        next_pc_s  = pc_plus4_s;
        if (jump_reg) begin
            pc_sel_s = 2'b11;
        end else if (jump) begin
            pc_sel_s = 2'b10;
        end else if (branch && zero) begin
            pc_sel_s = 2'b01;
        end else begin
            pc_sel_s = 2'b00;
        end
        case (pc_sel_s)
            2'b00:   next_pc_s = pc_plus4_s;
            2'b01:   next_pc_s = branch_target;
            2'b10:   next_pc_s = jump_target;
            2'b11:   next_pc_s = reg_target;
            default: next_pc_s = pc_plus4_s;
        endcase
    end

    // Retirement decision: a committing cycle either retires or traps.
    always_comb begin
        commit_s = ((state_r == ST_RUN) || (state_r == ST_STEP)) && !misalign_r;
        trap_s   = commit_s && target_misaligned(pc_sel_s, next_pc_s);
        retire_s = commit_s && !trap_s;
    end

    // Mode transitions; a trap or a latched misalign pins the core in HALT.
    always_comb begin
        state_next_s = ST_HALT;
        if (trap_s || misalign_r) begin
            state_next_s = ST_HALT;
        end else begin
            case (state_r)
                ST_RUN:  state_next_s = halt_req ? ST_HALT : ST_RUN;
                ST_HALT: begin
                    if (halt_req) begin
                        state_next_s = ST_HALT;
                    end else if (run_req) begin
                        state_next_s = ST_RUN;
                    end else if (step_req) begin
                        state_next_s = ST_STEP;
                    end else begin
                        state_next_s = ST_HALT;
                    end
                end
                ST_STEP: state_next_s = (run_req && !halt_req) ? ST_RUN : ST_HALT;
                default: state_next_s = ST_HALT;
            endcase
        end
    end

    // State, PC, retirement counter and sticky misalign flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r    <= RESET_STATE;
            pc_r       <= RESET_PC;
            count_r    <= 32'd0;
            misalign_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (retire_s) begin
                pc_r    <= next_pc_s;
                count_r <= count_r + 32'd1;
            end
            if (trap_s) begin
                misalign_r <= 1'b1;
            end
        end
    end

    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign pc_sel      = pc_sel_s;
    assign commit      = commit_s;
    assign state       = state_r;
    assign instr_count = count_r;
    assign misalign    = misalign_r;

endmodule
